// File: rtl/ones_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : ones_window_accumulator
// Purpose  : Running sum of the last WINDOW accepted ones-count samples, kept
//            in a circular buffer. A registered fire flag is raised once the
//            window is full and the sum reaches a runtime threshold.
// Ports    : clock_i        - clock, rising edge
//            reset_i        - asynchronous active-low reset
//            clear_i        - synchronous window flush (beats valid_i)
//            valid_i        - ones_i carries a sample this cycle
//            ones_i         - per-sample ones count (clamped to INPUT_FEATURES)
//            threshold_i    - fire threshold, captured with each sample
//            sum_o          - sum of the last min(fill, WINDOW) samples
//            valid_o        - one-cycle pulse: sum_o / fire_o were updated
//            window_full_o  - WINDOW samples seen since reset/clear
//            fire_o         - window_full_o && sum_o >= captured threshold
// Revision : 1.0 - initial release
// ============================================================================
module ones_window_accumulator #(
    parameter int   INPUT_FEATURES = 4,
    parameter int   WINDOW         = 4,
    localparam int  COUNT_WIDTH    = $clog2(INPUT_FEATURES + 1),
    localparam int  SUM_WIDTH      = $clog2(WINDOW * INPUT_FEATURES + 1)
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   valid_i,
    input  logic [COUNT_WIDTH-1:0] ones_i,
    input  logic [SUM_WIDTH-1:0]   threshold_i,
    output logic [SUM_WIDTH-1:0]   sum_o,
    output logic                   valid_o,
    output logic                   window_full_o,
    output logic                   fire_o
);

    localparam int c_PTR_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_FILL_W = $clog2(WINDOW + 1);
    localparam int c_EXT_W  = SUM_WIDTH + 1;

    localparam logic [c_PTR_W-1:0]     c_PTR_LAST  = c_PTR_W'(WINDOW - 1);
    localparam logic [c_FILL_W-1:0]    c_FILL_LAST = c_FILL_W'(WINDOW - 1);
    localparam logic [COUNT_WIDTH-1:0] c_SAT_MAX   = COUNT_WIDTH'(INPUT_FEATURES);

    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_FILLING = 2'd1;
    localparam logic [1:0] c_ST_FULL    = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     w_ptr_next;
    logic [c_FILL_W-1:0]    r_fill;
    logic [COUNT_WIDTH-1:0] r_buf [WINDOW];
    logic [SUM_WIDTH-1:0]   r_sum;
    logic                   r_valid;
    logic                   r_full;
    logic                   r_fire;

    logic                   w_accept;
    logic [COUNT_WIDTH-1:0] w_sat;
    logic [c_EXT_W-1:0]     w_old;
    logic [c_EXT_W-1:0]     w_sum_ext;
    logic                   w_full_next;
    logic                   w_fire_next;

    assign w_accept = valid_i & ~clear_i;

    // Out-of-range counts clamp so the sum can never exceed WINDOW*INPUT_FEATURES.
    assign w_sat = (ones_i > c_SAT_MAX) ? c_SAT_MAX : ones_i;

    // Only a full window has an oldest entry to retire; before that the
    // buffer slot under the pointer is stale and must not be subtracted.
    assign w_old     = (r_state == c_ST_FULL) ? c_EXT_W'(r_buf[r_wr_ptr]) : '0;
    assign w_sum_ext = {1'b0, r_sum} + c_EXT_W'(w_sat) - w_old;

    assign w_ptr_next  = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
    assign w_full_next = (w_state_next == c_ST_FULL);
    assign w_fire_next = w_full_next && (w_sum_ext >= {1'b0, threshold_i});

    // Next-state logic: transitions only on an accepted sample, clear wins.
    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = c_ST_EMPTY;
        end else if (valid_i) begin
            case (r_state)
                c_ST_EMPTY:   w_state_next = (WINDOW == 1) ? c_ST_FULL : c_ST_FILLING;
                c_ST_FILLING: if (r_fill == c_FILL_LAST) w_state_next = c_ST_FULL;
                c_ST_FULL:    w_state_next = c_ST_FULL;
                default:      w_state_next = c_ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= c_ST_EMPTY;
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_sum    <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_fire   <= 1'b0;
            for (int i = 0; i < WINDOW; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_valid <= w_accept;
            if (clear_i) begin
                // Buffer contents are left stale; fill gates their reuse.
                r_wr_ptr <= '0;
                r_fill   <= '0;
                r_sum    <= '0;
                r_full   <= 1'b0;
                r_fire   <= 1'b0;
            end else if (valid_i) begin
                r_buf[r_wr_ptr] <= w_sat;
                r_wr_ptr        <= w_ptr_next;
                r_sum           <= w_sum_ext[SUM_WIDTH-1:0];
                r_full          <= w_full_next;
                r_fire          <= w_fire_next;
                if (r_state != c_ST_FULL) begin
                    r_fill <= r_fill + c_FILL_W'(1);
                end
            end
        end
    end

    assign sum_o         = r_sum;
    assign valid_o       = r_valid;
    assign window_full_o = r_full;
    assign fire_o        = r_fire;

endmodule
`default_nettype wire

// File: doc/ones_window_accumulator.md
Name: ones_window_accumulator

Overview:
Downstream stage of the ones counter. Consumes the per-sample ones count and keeps a running sum over the last WINDOW valid samples in a circular buffer. It compares the sum against a runtime threshold and raises a registered fire flag once the window has filled. Its output drives the classification/decision logic.

Parameters:
INPUT_FEATURES, 4, number of features counted upstream; the maximum legal ones_i value
WINDOW, 4, number of samples summed; legal range 1..64
COUNT_WIDTH, $clog2(INPUT_FEATURES+1), derived localparam; width of ones_i
SUM_WIDTH, $clog2(WINDOW*INPUT_FEATURES+1), derived localparam; width of the sum and threshold

Ports:
clock_i  input  1  clock; all state changes on the rising edge
reset_i  input  1  reset, asynchronous, active-low
clear_i  input  1  synchronous flush of the window
valid_i  input  1  ones_i carries a new sample this cycle
ones_i  input  COUNT_WIDTH  ones count from the upstream ones counter
threshold_i  input  SUM_WIDTH  fire threshold, sampled on every accepted sample
sum_o  output  SUM_WIDTH  sum of the last min(fill, WINDOW) samples
valid_o  output  1  one-cycle pulse; sum_o and fire_o were updated
window_full_o  output  1  WINDOW samples accumulated since reset/clear
fire_o  output  1  window_full and sum >= threshold

Behaviour:
- Reset (reset_i low, asynchronous) clears the following to 0: sum_o, valid_o, window_full_o, fire_o, write pointer, fill count, and all buffer entries. FSM goes to EMPTY.
- FSM states:
  - EMPTY: fill = 0.
  - FILLING: 0 < fill < WINDOW.
  - FULL: fill = WINDOW.
- FSM transitions, each taken only on an accepted sample:
  - EMPTY -> FILLING, or EMPTY -> FULL directly if WINDOW = 1.
  - FILLING -> FULL when fill reaches WINDOW.
  - FULL stays FULL.
- Accepted sample means valid_i = 1 and clear_i = 0.
- Input saturation: s = min(ones_i, INPUT_FEATURES). Out-of-range counts clamp and never overflow the sum.
- In FULL, on an accepted sample:
  - next sum = sum - buf[wr_ptr] + s.
  - buf[wr_ptr] <= s.
- In EMPTY or FILLING, on an accepted sample:
  - next sum = sum + s.
  - buf[wr_ptr] <= s.
  - fill increments.
- wr_ptr increments and wraps from WINDOW-1 to 0. Arithmetic is done in SUM_WIDTH+1 bits; the result is always within 0..WINDOW*INPUT_FEATURES.
- Latency is 1 cycle. In the cycle after an accepted sample:
  - valid_o = 1.
  - sum_o holds the new sum.
  - window_full_o = (new state == FULL).
  - fire_o = window_full_o && (new sum >= threshold_i as sampled with that sample).
- Between accepted samples, sum_o, window_full_o and fire_o hold their values and valid_o = 0. Changing threshold_i has no effect until the next accepted sample.
- valid_i may be asserted every cycle (full throughput, no backpressure). Gaps are allowed; a gap is not a sample.
- clear_i = 1 (synchronous; wins over valid_i in the same cycle; that sample is dropped):
  - Next cycle: sum_o, window_full_o, fire_o, wr_ptr and fill are 0; FSM is EMPTY; valid_o = 0.
  - Buffer contents need not be zeroed because fill gates their use.
- Reset asserted mid-operation overrides everything immediately. Operation resumes in EMPTY on the first edge after reset_i goes high.
- threshold_i = 0: fire_o = 1 on every update once the window is FULL, and never before FULL.

Test Plan:
- Reset, then valid_i with ones_i = 4,4,4,4, threshold_i = 12:
  - sum_o = 4, 8, 12, 16 on successive valid_o pulses.
  - window_full_o rises with sum 16, and fire_o = 1 on that same pulse.
  - fire_o = 0 on all earlier pulses, including sum 12.
- Continue the previous sequence with ones_i = 0, then 1:
  - sum_o = 12 (fire_o = 1), then sum_o = 9 (fire_o = 0).
  - Confirms the oldest entry is subtracted and wr_ptr wraps.
- Saturation: ones_i = 7 (COUNT_WIDTH = 3) while EMPTY -> sum_o = 4. Eight consecutive ones_i = 7 -> sum_o stays at 16 and never wraps.
- Gaps: valid_i high 1 cycle, low 3 cycles, repeated with ones_i = 2 -> sum_o increments by 2 only on valid_o pulses and holds between them; valid_o is exactly one cycle wide.
- Clear: clear_i and valid_i both high with ones_i = 3 while FULL at sum 10 -> next cycle sum_o = 0, window_full_o = 0, fire_o = 0, valid_o = 0; the next sample ones_i = 3 gives sum_o = 3.
- Asynchronous reset: drop reset_i mid-cycle while FULL -> outputs go to 0 before the next clock edge. After release, ones_i = 1 gives sum_o = 1 and window_full_o = 0.
